// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and descriptor payload for the NTT butterfly scheduler.
package ntt_pkg;

    localparam int unsigned NTT_N      = 256;
    localparam int unsigned NTT_LOG_N  = 8;
    localparam int unsigned NTT_AW     = NTT_LOG_N;
    localparam int unsigned NTT_WB_LAT = 2;
    localparam int unsigned TOTAL_BF   = (NTT_N / 2) * NTT_LOG_N;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        BUBBLE = 2'd2,
        DRAIN  = 2'd3
    } ntt_state_e;

    typedef struct packed {
        logic [NTT_AW-1:0]    addr_x;
        logic [NTT_AW-1:0]    addr_y;
        logic [NTT_AW-1:0]    tf_addr;
        logic [NTT_LOG_N-1:0] stage;
        logic                 last_issue;
    } bf_desc_t;

endpackage

// File: rtl/ntt_sched_if.sv
// Control and descriptor bus between the NTT FSM/datapath and the butterfly scheduler.
interface ntt_sched_if
    import ntt_pkg::*;
#(
    parameter int unsigned AW    = NTT_AW,
    parameter int unsigned LOG_N = NTT_LOG_N
);
    logic             start;
    logic             busy;
    logic             done;
    logic             bf_valid;
    logic             bf_ready;
    logic [AW-1:0]    addr_x;
    logic [AW-1:0]    addr_y;
    logic [AW-1:0]    tf_addr;
    logic [LOG_N-1:0] stage;
    logic             last_issue;

    modport master (
        input  start, bf_ready,
        output busy, done, bf_valid, addr_x, addr_y, tf_addr, stage, last_issue
    );

    modport slave (
        output start, bf_ready,
        input  busy, done, bf_valid, addr_x, addr_y, tf_addr, stage, last_issue
    );
endinterface

// File: rtl/ntt_idx_step.sv
// Combinational next-index step for the (stage, block, j) walk of the Cooley-Tukey schedule.
module ntt_idx_step
    import ntt_pkg::*;
#(
    parameter int unsigned N  = NTT_N,
    parameter int unsigned AW = NTT_AW
) (
    input  logic [AW-1:0] j,
    input  logic [AW-1:0] start_ix,
    input  logic [AW:0]   len,
    input  logic [AW-1:0] m,
    output logic [AW-1:0] j_nxt_c,
    output logic [AW-1:0] start_ix_nxt_c,
    output logic [AW:0]   len_nxt_c,
    output logic [AW-1:0] m_nxt_c,
    output logic          end_of_block_c,
    output logic          end_of_stage_c,
    output logic          end_of_transform_c
);
    localparam int unsigned LW = AW + 1;

    logic [LW-1:0] j_inc;
    logic [LW-1:0] blk_end;
    logic [LW-1:0] next_start;
    logic          more_blocks;

    // All block-boundary arithmetic is carried at AW+1 bits so start_ix+2*len == N does not wrap.
    always_comb begin
        j_inc              = LW'(j) + LW'(1);
        blk_end            = LW'(start_ix) + len;
        next_start         = LW'(start_ix) + (len << 1);
        more_blocks        = next_start < LW'(N);
        end_of_block_c     = !(j_inc < blk_end);
        end_of_stage_c     = end_of_block_c && !more_blocks;
        end_of_transform_c = end_of_stage_c && (len == LW'(1));
        j_nxt_c            = j + AW'(1);
        start_ix_nxt_c     = start_ix;
        len_nxt_c          = len;
        m_nxt_c            = m;
        if (end_of_block_c) begin
            m_nxt_c = m + AW'(1);
            if (more_blocks) begin
                j_nxt_c        = AW'(next_start);
                start_ix_nxt_c = AW'(next_start);
            end else begin
                j_nxt_c        = '0;
                start_ix_nxt_c = '0;
                len_nxt_c      = len >> 1;
            end
        end
    end
endmodule

// File: rtl/ntt_sched.sv
// Butterfly schedule controller: issues (x, y, twiddle) descriptors with write-back bubbles between stages.
module ntt_sched
    import ntt_pkg::*;
#(
    parameter int unsigned N      = NTT_N,
    parameter int unsigned LOG_N  = NTT_LOG_N,
    parameter int unsigned AW     = NTT_AW,
    parameter int unsigned WB_LAT = NTT_WB_LAT
) (
    input  logic         clk,
    input  logic         rst,
    ntt_sched_if.master  bus
);
    localparam int unsigned LW         = AW + 1;
    localparam int unsigned SW         = LOG_N;
    localparam int unsigned DW         = 3;
    localparam int unsigned DRAIN_INIT = (WB_LAT > 0) ? WB_LAT - 1 : 0;

    ntt_state_e    state;
    logic [AW-1:0] j;
    logic [AW-1:0] start_ix;
    logic [AW-1:0] m;
    logic [LW-1:0] len;
    logic [DW-1:0] drain;

    logic [AW-1:0] j_nxt_c;
    logic [AW-1:0] start_ix_nxt_c;
    logic [LW-1:0] len_nxt_c;
    logic [AW-1:0] m_nxt_c;
    logic          end_of_block_c;
    logic          end_of_stage_c;
    logic          end_of_transform_c;

    ntt_idx_step #(.N(N), .AW(AW)) u_step (
        .j                  (j),
        .start_ix           (start_ix),
        .len                (len),
        .m                  (m),
        .j_nxt_c            (j_nxt_c),
        .start_ix_nxt_c     (start_ix_nxt_c),
        .len_nxt_c          (len_nxt_c),
        .m_nxt_c            (m_nxt_c),
        .end_of_block_c     (end_of_block_c),
        .end_of_stage_c     (end_of_stage_c),
        .end_of_transform_c (end_of_transform_c)
    );

    // Descriptor outputs are loaded together with the index registers so they hold across stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            j              <= '0;
            start_ix       <= '0;
            m              <= '0;
            len            <= '0;
            drain          <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.bf_valid   <= 1'b0;
            bus.last_issue <= 1'b0;
            bus.addr_x     <= '0;
            bus.addr_y     <= '0;
            bus.tf_addr    <= '0;
            bus.stage      <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.done) begin
                        len            <= LW'(N / 2);
                        start_ix       <= '0;
                        j              <= '0;
                        m              <= '0;
                        bus.stage      <= '0;
                        bus.addr_x     <= '0;
                        bus.addr_y     <= AW'(N / 2);
                        bus.tf_addr    <= AW'(1);
                        bus.bf_valid   <= 1'b1;
                        bus.last_issue <= 1'b0;
                        bus.busy       <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.bf_valid && bus.bf_ready) begin
                        j        <= j_nxt_c;
                        start_ix <= start_ix_nxt_c;
                        len      <= len_nxt_c;
                        if (end_of_block_c) begin
                            m <= m_nxt_c;
                        end
                        if (!end_of_stage_c) begin
                            bus.addr_x     <= j_nxt_c;
                            bus.addr_y     <= AW'(LW'(j_nxt_c) + len);
                            bus.tf_addr    <= m_nxt_c + AW'(1);
                            bus.last_issue <= (bus.stage == SW'(LOG_N - 1)) && (j_nxt_c == AW'(N - 2));
                        end else if (!end_of_transform_c) begin
                            if (WB_LAT == 0) begin
                                bus.stage   <= bus.stage + SW'(1);
                                bus.addr_x  <= '0;
                                bus.addr_y  <= AW'(len_nxt_c);
                                bus.tf_addr <= m_nxt_c + AW'(1);
                            end else begin
                                bus.bf_valid <= 1'b0;
                                drain        <= DW'(DRAIN_INIT);
                                state        <= BUBBLE;
                            end
                        end else begin
                            bus.bf_valid   <= 1'b0;
                            bus.last_issue <= 1'b0;
                            if (WB_LAT == 0) begin
                                bus.done <= 1'b1;
                                bus.busy <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                drain <= DW'(DRAIN_INIT);
                                state <= DRAIN;
                            end
                        end
                    end
                end
                BUBBLE: begin
                    if (drain == '0) begin
                        bus.stage    <= bus.stage + SW'(1);
                        bus.addr_x   <= j;
                        bus.addr_y   <= AW'(LW'(j) + len);
                        bus.tf_addr  <= m + AW'(1);
                        bus.bf_valid <= 1'b1;
                        state        <= ISSUE;
                    end else begin
                        drain <= drain - DW'(1);
                    end
                end
                DRAIN: begin
                    if (drain == '0) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        drain <= drain - DW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/ntt_sched.md
Name: ntt_sched

Overview:
Butterfly schedule controller for the 256-point forward NTT datapath (Cooley-Tukey, len halving from N/2 to 1). On a start pulse it walks every (stage, block, j) and issues one butterfly descriptor per handshake: X address, Y address and twiddle ROM address. It inserts a write-back bubble at each stage boundary so that a pipelined butterfly unit never reads a word the previous stage has not yet written. It sits between the top-level NTT FSM and the coefficient memory, BU and twiddle ROM.

Parameters:
N, 256, transform length; power of two, at least 4.
LOG_N, 8, log2(N); sets the stage count and the stage port width.
AW, 8, address width, equal to LOG_N.
WB_LAT, 2, cycles from BU issue to memory write-back; 0 to 7 allowed.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous to clk, active-high
start  in  1  one-cycle request; honoured only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the schedule and write-back are complete
bf_valid  out  1  descriptor on addr_x, addr_y, tf_addr and stage is valid
bf_ready  in  1  datapath accepts the descriptor this cycle
addr_x  out  AW  j
addr_y  out  AW  j+len
tf_addr  out  AW  twiddle ROM address, m+1
stage  out  LOG_N  stage index; 0 means len=N/2
last_issue  out  1  qualifies the final descriptor of the whole transform

Behaviour:
- Handshake: a transfer occurs when bf_valid and bf_ready are both high. While bf_valid=1 and bf_ready=0, all descriptor outputs hold stable. bf_valid never drops without a transfer.
- Reset: state=IDLE; busy=0, done=0, bf_valid=0, last_issue=0; addr_x=0, addr_y=0, tf_addr=0, stage=0. A reset mid-run abandons the schedule immediately; no done pulse follows.
- Internal registers: len (AW+1 bits), start_ix, j, m (block counter), drain counter (3 bits).
- States:
  - IDLE: on start, load len=N/2, start_ix=0, j=0, m=0, stage=0, then go to ISSUE. bf_valid rises the next cycle.
  - ISSUE: bf_valid=1. On each transfer:
    - If j+1 < start_ix+len, then j++.
    - Else, if start_ix+2*len < N, advance to the next block: start_ix += 2*len, j = new start_ix, m++.
    - Else, if len > 1, this is the end of the stage: go to BUBBLE with drain=WB_LAT.
    - Else, this is the final transfer: go to DRAIN with drain=WB_LAT.
  - BUBBLE: bf_valid=0. When drain reaches 0 (same cycle if WB_LAT=0): len >>= 1, start_ix=0, j=0, m++, stage++, return to ISSUE. Net effect: exactly WB_LAT idle cycles between the last transfer of a stage and the first valid of the next.
  - DRAIN: bf_valid=0; count down. done pulses exactly WB_LAT+1 cycles after the final transfer, then the state returns to IDLE and busy drops in the same cycle as done.
- Counting: m increments once per block, across all stages. tf_addr therefore spans 1 to N-1, and each value is used for exactly one block. Total transfers = (N/2)*LOG_N, which is 1024 for the defaults.
- Arithmetic: addr_y = j+len never exceeds N-1. The comparison start_ix+2*len is done at AW+1 bits to avoid wrap.
- last_issue=1 only while the final descriptor is presented (stage=LOG_N-1, j=N-2).
- A start asserted while not in IDLE is ignored and not queued. A start in the same cycle that done pulses is also ignored.
- The schedule is unaffected by stall length; only the transfer count and bubble timing are observable.

Decomposition:
- Shared package ntt_pkg holds N, LOG_N, AW and WB_LAT defaults, the state encoding (IDLE, ISSUE, BUBBLE, DRAIN), and the localparam TOTAL_BF = (N/2)*LOG_N.
- One natural sub-module, ntt_idx_step: a combinational next-index step taking j, start_ix, len and m and returning the next values plus end_of_block, end_of_stage and end_of_transform flags. The FSM and drain counter stay in ntt_sched.

Test Plan:
- Defaults, bf_ready tied high, start pulse at cycle t:
  - bf_valid rises at t+1.
  - First descriptors are (0,128,tf1), (1,129,tf1) and so on; the stage-0 last descriptor is (127,255,tf1).
  - 2 bubble cycles follow, then (0,64,tf2) at stage 1, with (128,192,tf3) later in that stage.
- Final stage:
  - Descriptors run (0,1,tf128), (2,3,tf129) through (254,255,tf255), with last_issue high only on the last one.
  - Exactly 1024 transfers in total.
  - done pulses 3 cycles after the final transfer.
- WB_LAT=0 with ready always high:
  - 1024 consecutive valid cycles with no gaps.
  - done pulses 1 cycle after the final transfer.
- Random bf_ready stalls (about 30% low):
  - Outputs stay stable during every stall.
  - The descriptor sequence is identical to the unstalled run.
  - Scoreboard checks each (addr_x, addr_y, tf_addr) triple against a golden loop model.
- start asserted repeatedly during ISSUE and BUBBLE -> no restart and sequence unchanged. start asserted on the done cycle -> ignored. A later start in IDLE -> a full second run.
- rst asserted for 1 cycle at transfer 500 -> the next cycle shows all outputs at reset values and no done pulse. A new start gives a sequence that again begins at (0,128,tf1).
